// File: rtl/dense_pkg.sv
// Shared geometry and bank-state encoding for the dense feature-map ping-pong buffer.
package dense_pkg;

  localparam int DATA_W    = 16;
  localparam int ROW_WORDS = 25;
  localparam int ROW_NUM   = 16;
  localparam int DEPTH     = ROW_WORDS * ROW_NUM;

  typedef enum logic [1:0] {
    BANK_EMPTY   = 2'd0,
    BANK_FILLING = 2'd1,
    BANK_FULL    = 2'd2
  } bank_state_e;

endpackage

// File: rtl/dense_fmap_pingpong_buf_ram.sv
// One feature-map bank: word-granular writes, whole-row registered reads.
// The storage array is intentionally not reset; only the read register is.
module fmap_bank_ram
  import dense_pkg::*;
#(
  parameter int DATA_W    = dense_pkg::DATA_W,
  parameter int ROW_WORDS = dense_pkg::ROW_WORDS,
  parameter int ROW_NUM   = dense_pkg::ROW_NUM,
  localparam int ROW_AW   = $clog2(ROW_NUM),
  localparam int LANE_AW  = $clog2(ROW_WORDS)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        wr_en_i,
  input  logic [ROW_AW-1:0]           wr_row_i,
  input  logic [LANE_AW-1:0]          wr_lane_i,
  input  logic [DATA_W-1:0]           wr_data_i,
  input  logic                        rd_en_i,
  input  logic [ROW_AW-1:0]           rd_row_i,
  output logic [DATA_W*ROW_WORDS-1:0] rd_row_o
);

  logic [DATA_W-1:0]           mem_q [ROW_NUM][ROW_WORDS];
  logic [DATA_W*ROW_WORDS-1:0] rd_row_q;

  // Single-word write into the addressed row/lane.
  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_row_i][wr_lane_i] <= wr_data_i;
  end

  // Capture a whole row; the register holds between reads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_row_q <= '0;
    end else if (rd_en_i) begin
      for (int k = 0; k < ROW_WORDS; k++) begin
        rd_row_q[k*DATA_W +: DATA_W] <= mem_q[rd_row_i][k];
      end
    end
  end

  assign rd_row_o = rd_row_q;

endmodule

// File: rtl/dense_fmap_pingpong_buf.sv
// Two-bank ping-pong buffer between a word-writing producer layer and a
// row-reading consumer layer. The producer fills bank[wb] while the consumer
// reads bank[rb]; the banks swap roles on fill completion and on release.
module dense_fmap_pingpong_buf
  import dense_pkg::*;
#(
  parameter int DATA_W    = dense_pkg::DATA_W,
  parameter int ROW_WORDS = dense_pkg::ROW_WORDS,
  parameter int ROW_NUM   = dense_pkg::ROW_NUM
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        wr_en_in,
  input  logic [31:0]                 wr_addr_in,
  input  logic [DATA_W-1:0]           wr_data_in,
  output logic                        wr_ready,
  input  logic                        rd_en_in,
  input  logic [31:0]                 rd_addr_in_1P,
  output logic [DATA_W*ROW_WORDS-1:0] rd_data_out_25P,
  output logic                        rd_valid,
  output logic                        buf_full,
  input  logic                        rd_release,
  output logic                        fill_done,
  output logic                        addr_err
);

  localparam int DEPTH_L  = ROW_WORDS * ROW_NUM;
  localparam int CNT_W    = $clog2(DEPTH_L);
  localparam int ROW_AW   = $clog2(ROW_NUM);
  localparam int LANE_AW  = $clog2(ROW_WORDS);
  localparam int ROW_BITS = DATA_W * ROW_WORDS;

  bank_state_e [1:0] bank_st_q, bank_st_d;
  logic              wb_q, wb_d;
  logic              rb_q, rb_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              addr_err_q, addr_err_d;
  logic              fill_done_q;
  logic              rd_valid_q;
  logic              rd_sel_q;

  logic              wr_in_range, rd_in_range;
  logic              wr_acc, fill_cmpl, rd_acc, rel_acc;
  logic [ROW_AW-1:0] wr_row, rd_row;
  logic [LANE_AW-1:0] wr_lane;
  logic [ROW_BITS-1:0] bank_row [2];

  assign wr_ready    = (bank_st_q[wb_q] != BANK_FULL);
  assign buf_full    = (bank_st_q[rb_q] == BANK_FULL);
  assign wr_in_range = (wr_addr_in < 32'(DEPTH_L));
  assign rd_in_range = (rd_addr_in_1P < 32'(ROW_NUM));

  assign wr_acc    = wr_en_in && wr_ready && wr_in_range;
  assign fill_cmpl = wr_acc && (cnt_q == CNT_W'(DEPTH_L - 1));
  assign rd_acc    = rd_en_in && buf_full && rd_in_range;
  assign rel_acc   = rd_release && buf_full;

  assign wr_row  = ROW_AW'(wr_addr_in / 32'(ROW_WORDS));
  assign wr_lane = LANE_AW'(wr_addr_in % 32'(ROW_WORDS));
  assign rd_row  = ROW_AW'(rd_addr_in_1P);

  // Bank bookkeeping: release is applied first so that completion wins on a shared bank.
  always_comb begin
    bank_st_d  = bank_st_q;
    wb_d       = wb_q;
    rb_d       = rb_q;
    cnt_d      = cnt_q;
    addr_err_d = addr_err_q;
    if ((wr_en_in && wr_ready && !wr_in_range) || (rd_en_in && !rd_in_range)) begin
      addr_err_d = 1'b1;
    end
    if (rel_acc) begin
      bank_st_d[rb_q] = BANK_EMPTY;
      rb_d            = ~rb_q;
    end
    if (wr_acc) begin
      if (fill_cmpl) begin
        bank_st_d[wb_q] = BANK_FULL;
        wb_d            = ~wb_q;
        cnt_d           = '0;
      end else begin
        bank_st_d[wb_q] = BANK_FILLING;
        cnt_d           = cnt_q + CNT_W'(1);
      end
    end
  end

  // State registers; reset drops any partial fill and pending read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bank_st_q   <= {BANK_EMPTY, BANK_EMPTY};
      wb_q        <= 1'b0;
      rb_q        <= 1'b0;
      cnt_q       <= '0;
      addr_err_q  <= 1'b0;
      fill_done_q <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_sel_q    <= 1'b0;
    end else begin
      bank_st_q   <= bank_st_d;
      wb_q        <= wb_d;
      rb_q        <= rb_d;
      cnt_q       <= cnt_d;
      addr_err_q  <= addr_err_d;
      fill_done_q <= fill_cmpl;
      rd_valid_q  <= rd_acc;
      if (rd_acc) rd_sel_q <= rb_q;
    end
  end

  for (genvar g = 0; g < 2; g++) begin : g_bank
    fmap_bank_ram #(
      .DATA_W   (DATA_W),
      .ROW_WORDS(ROW_WORDS),
      .ROW_NUM  (ROW_NUM)
    ) u_ram (
      .clk      (clk),
      .rst      (rst),
      .wr_en_i  (wr_acc && (wb_q == 1'(g))),
      .wr_row_i (wr_row),
      .wr_lane_i(wr_lane),
      .wr_data_i(wr_data_in),
      .rd_en_i  (rd_acc && (rb_q == 1'(g))),
      .rd_row_i (rd_row),
      .rd_row_o (bank_row[g])
    );
  end

  // Each bank's read register only moves on its own read, so muxing by the
  // last-read bank holds the output steady while rd_valid is low.
  assign rd_data_out_25P = bank_row[rd_sel_q];
  assign rd_valid        = rd_valid_q;
  assign fill_done       = fill_done_q;
  assign addr_err        = addr_err_q;

endmodule

// File: doc/dense_fmap_pingpong_buf.md
DENSE_FMAP_PINGPONG_BUF -- requirements
Module: dense_fmap_pingpong_buf

Interface
REQ-001 SHALL have parameter DATA_W, default 16, word width.
REQ-002 SHALL have parameter ROW_WORDS, default 25, words per row (one 25P read).
REQ-003 SHALL have parameter ROW_NUM, default 16, rows per bank (DEPTH = ROW_WORDS*ROW_NUM = 400 words).
REQ-004 SHALL have port clk, input, 1, sole clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1, reset; asynchronous, active-high.
REQ-006 SHALL have port wr_en_in, input, 1, write strobe from the producer layer.
REQ-007 SHALL have port wr_addr_in, input, 32, linear word address.
REQ-008 SHALL have port wr_data_in, input, DATA_W, write word.
REQ-009 SHALL have port wr_ready, output, 1, write bank can accept words.
REQ-010 SHALL have port rd_en_in, input, 1, row read strobe from the consumer layer.
REQ-011 SHALL have port rd_addr_in_1P, input, 32, row index.
REQ-012 SHALL have port rd_data_out_25P, output, DATA_W*ROW_WORDS, row data; word k at bits [16k+15:16k].
REQ-013 SHALL have port rd_valid, output, 1, rd_data_out_25P valid this cycle.
REQ-014 SHALL have port buf_full, output, 1, read bank holds a complete feature map.
REQ-015 SHALL have port rd_release, input, 1, consumer finished with the read bank.
REQ-016 SHALL have port fill_done, output, 1, one-cycle pulse when a bank completes filling.
REQ-017 SHALL have port addr_err, output, 1, sticky out-of-range access flag.

Function
REQ-018 SHALL hold two banks, A and B; each bank in state EMPTY, FILLING or FULL.
REQ-019 SHALL keep a write-bank pointer wb and a read-bank pointer rb, both 0 (A) after reset.
REQ-020 SHALL assert wr_ready when bank[wb] is EMPTY or FILLING.
REQ-021 SHALL accept a write when wr_en_in && wr_ready && wr_addr_in < DEPTH: store the word at row addr/ROW_WORDS, lane addr%ROW_WORDS; increment the fill counter; EMPTY->FILLING.
REQ-022 SHALL ignore writes when wr_ready=0, without any state change.
REQ-023 SHALL ignore writes with wr_addr_in >= DEPTH and set addr_err.
REQ-024 SHALL count accepted writes, duplicates included; at the DEPTH-th accepted write, set bank[wb] FULL, toggle wb, clear the counter and pulse fill_done next cycle.
REQ-025 SHALL drive buf_full = (bank[rb]==FULL).
REQ-026 SHALL, on rd_en_in && buf_full && rd_addr_in_1P < ROW_NUM, present the row on rd_data_out_25P with rd_valid=1 exactly one cycle later.
REQ-027 SHALL, on a read with buf_full=0, give rd_valid=0 next cycle and leave data unchanged.
REQ-028 SHALL, on a read with rd_addr_in_1P >= ROW_NUM, give rd_valid=0 next cycle and set addr_err.
REQ-029 SHALL hold rd_data_out_25P at its last value while rd_valid=0.
REQ-030 SHALL, on rd_release && buf_full, set bank[rb] EMPTY and toggle rb; rd_release with buf_full=0 is ignored.
REQ-031 SHALL, when release and fill completion occur in the same cycle, apply both; if they target the same bank, completion wins and the bank stays FULL.
REQ-032 SHALL, when a read and a release occur in the same cycle, return the pre-release bank's row.
REQ-033 SHALL not clear bank contents on release; each fill overwrites them.

Reset
REQ-034 SHALL, on rst, set both banks EMPTY, wb=rb=0, counter=0, wr_ready=1, rd_valid=0, buf_full=0, fill_done=0, addr_err=0, rd_data_out_25P=0; storage contents are undefined.
REQ-035 SHALL discard any partial fill or pending read when rst asserts mid-operation; the first cycle after rst release behaves as post-reset.

Structure
REQ-036 SHALL take DATA_W, ROW_WORDS, ROW_NUM, DEPTH and the bank-state encoding from a shared package dense_pkg.
REQ-037 SHALL instantiate a sub-module fmap_bank_ram twice: single-word write, full-row registered read.

Verification
REQ-038 SHALL cover: after reset, write 400 words with data=addr -> fill_done pulse, buf_full=1; read row 3 -> next cycle lanes 0..24 = 75..99.
REQ-039 SHALL cover: fill A, fill B -> wr_ready=0; write 0xBEEF at addr 0 -> ignored; release -> wr_ready=1; read row 0 -> B data.
REQ-040 SHALL cover: write at addr 400 -> addr_err=1, counter unchanged; read row 16 with buf_full=1 -> rd_valid=0.
REQ-041 SHALL cover: 400th write to B in the same cycle as release of A -> B FULL, rb=1, wb=0, fill_done=1.
REQ-042 SHALL cover: rst after 200 writes -> counter 0, buf_full=0; a fresh 400-word fill completes normally.
